// File: rtl/scan_sequencer.sv
// scan_sequencer: round-robin channel scanner for a 3-to-8 decoder.
// Blanking gap before each channel's active window; frame_done on wrap.
module scan_sequencer #(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               sel_valid,
    output logic               frame_done,
    output logic               busy
);

    localparam int CW = (DWELL_W > 8) ? DWELL_W : 8;
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
        $error("scan_sequencer: BLANK_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fd_q, fd_d;
    logic [CW-1:0] dwell_load;
    logic [2:0]    idx_next;
    logic          run_ok;

    // First set bit of m strictly after cur, wrapping; cur itself last.
    function automatic logic [2:0] next_set(input logic [7:0] m,
                                            input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] j;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            j = cur + 3'(k);
            if (!found && m[j]) begin
                r     = j;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Dwell of zero still gives one active cycle.
    assign dwell_load = (dwell == '0) ? '0 : CW'(dwell - DWELL_W'(1));
    assign idx_next   = next_set(mask, idx_q);
    assign run_ok     = en && (mask != 8'h00);

    // State, index, counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
        end
    end

    // Next-state: blank countdown, active dwell, advance to next channel.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run_ok) begin
                    state_d = BLANK;
                    idx_d   = next_set(mask, 3'd7);
                    cnt_d   = BLANK_LOAD;
                end
            end
            BLANK: begin
                if (!run_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ACTIVE;
                    cnt_d   = dwell_load;
                end
            end
            ACTIVE: begin
                if (!run_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = BLANK;
                    idx_d   = idx_next;
                    cnt_d   = BLANK_LOAD;
                    fd_d    = (idx_next <= idx_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registered state.
    always_comb begin
        a          = idx_q[2];
        b          = idx_q[1];
        c          = idx_q[0];
        sel_valid  = (state_q == ACTIVE);
        busy       = (state_q != IDLE);
        frame_done = fd_q;
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed and random checks of scan_sequencer
// against a period/position reference model.
module tb_scan_sequencer;

    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  mask;
    logic [15:0] dwell;
    logic        a, b, c, sel_valid, frame_done, busy;
    logic [5:0]  got;

    int errors = 0;
    int checks = 0;

    // Model: running flag, channel, position inside period, latched dwell.
    bit m_run;
    bit m_fd;
    int m_ch;
    int m_t;
    int m_d;

    scan_sequencer #(.DWELL_W(16), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .en(en), .mask(mask), .dwell(dwell),
        .a(a), .b(b), .c(c), .sel_valid(sel_valid),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign got = {a, b, c, sel_valid, frame_done, busy};

    function automatic int lowest(input logic [7:0] m);
        for (int i = 0; i < 8; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_after(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++)
            if (m[(cur + k) % 8]) return (cur + k) % 8;
        return cur;
    endfunction

    function automatic logic [5:0] expv();
        logic [2:0] ch3;
        ch3 = m_ch[2:0];
        return {ch3, (m_run && m_t >= B), m_fd, m_run};
    endfunction

    // One clock edge: update the model from the sampled inputs, then settle.
    task automatic cycle();
        int nx;
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_ch = 0; m_t = 0; m_fd = 0;
        end else if (!m_run) begin
            m_fd = 0;
            if (en && mask != 0) begin
                m_run = 1; m_ch = lowest(mask); m_t = 0;
            end
        end else if (!en || mask == 0) begin
            m_run = 0; m_fd = 0;
        end else begin
            m_fd = 0;
            m_t++;
            if (m_t == B) m_d = (dwell == 0) ? 1 : int'(dwell);
            if (m_t == B + m_d) begin
                nx = next_after(mask, m_ch);
                m_fd = (nx <= m_ch);
                m_ch = nx;
                m_t = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; en = 0;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mask = 8'hFF; dwell = 16'd3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%b exp=000000", i, got);
            end
        end
        rst = 0;
        cycle();
        checks++;
        if ({busy, sel_valid, frame_done} !== 3'b100) begin
            errors++;
            $display("FAIL first_blank got=%b exp=100",
                     {busy, sel_valid, frame_done});
        end
        checks++;
        if (got !== expv()) begin
            errors++;
            $display("FAIL first_blank_model got=%b exp=%b", got, expv());
        end
    endtask

    task automatic test_full_sweep();
        int first, second, sel_cnt;
        do_reset();
        dwell = 16'd3; mask = 8'hFF; en = 1;
        first = -1; second = -1; sel_cnt = 0;
        for (int i = 0; i < 90; i++) begin
            cycle();
            checks++;
            if (got !== expv()) begin
                errors++;
                $display("FAIL sweep cyc=%0d got=%b exp=%b", i, got, expv());
            end
            if (i < 40 && sel_valid) sel_cnt++;
            if (frame_done) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        checks++;
        if (first != 40 || second != 80) begin
            errors++;
            $display("FAIL sweep_frame got=%0d,%0d exp=40,80", first, second);
        end
        checks++;
        if (sel_cnt != 24) begin
            errors++;
            $display("FAIL sweep_active got=%0d exp=24", sel_cnt);
        end
    endtask

    task automatic test_sparse();
        int seq[$];
        int want[6];
        int fds[$];
        logic prev_sel;
        want = '{2, 5, 7, 2, 5, 7};
        do_reset();
        dwell = 16'd1; mask = 8'b1010_0100; en = 1;
        prev_sel = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (got !== expv()) begin
                errors++;
                $display("FAIL sparse cyc=%0d got=%b exp=%b", i, got, expv());
            end
            if (sel_valid && !prev_sel) seq.push_back(int'({a, b, c}));
            if (frame_done) fds.push_back(i);
            prev_sel = sel_valid;
        end
        checks++;
        if (seq.size() != 6) begin
            errors++;
            $display("FAIL sparse_len got=%0d exp=6", seq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (seq[k] != want[k]) begin
                    errors++;
                    $display("FAIL sparse_seq[%0d] got=%0d exp=%0d",
                             k, seq[k], want[k]);
                end
            end
        end
        checks++;
        if (fds.size() != 2 || fds[0] != 9 || fds[1] != 18) begin
            errors++;
            $display("FAIL sparse_fd got=%p exp='{9,18}", fds);
        end
    endtask

    task automatic test_single();
        int fd_cnt, sel_cnt;
        do_reset();
        dwell = 16'd0; mask = 8'h10; en = 1;
        fd_cnt = 0; sel_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            checks++;
            if (got !== expv()) begin
                errors++;
                $display("FAIL single cyc=%0d got=%b exp=%b", i, got, expv());
            end
            if (frame_done) fd_cnt++;
            if (sel_valid) sel_cnt++;
        end
        checks++;
        if (fd_cnt != 9 || sel_cnt != 10) begin
            errors++;
            $display("FAIL single_counts got=%0d,%0d exp=9,10",
                     fd_cnt, sel_cnt);
        end
    endtask

    task automatic test_abort();
        int n;
        do_reset();
        dwell = 16'd2; mask = 8'hFF; en = 1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(sel_valid && {a, b, c} == 3'd3) && n < 100);
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL abort_wait got=timeout exp=idx3_active");
        end
        en = 0;
        cycle();
        checks++;
        if (got !== 6'b011_000 || got !== expv()) begin
            errors++;
            $display("FAIL abort_en got=%b exp=011000", got);
        end
        en = 1; mask = 8'h0C;
        cycle();
        checks++;
        if (got !== 6'b010_001 || got !== expv()) begin
            errors++;
            $display("FAIL restart got=%b exp=010001", got);
        end
        cycle();
        checks++;
        if (got !== expv()) begin
            errors++;
            $display("FAIL restart_blank got=%b exp=%b", got, expv());
        end
        mask = 8'h00;
        cycle();
        checks++;
        if (got !== 6'b010_000 || got !== expv()) begin
            errors++;
            $display("FAIL abort_mask got=%b exp=010000", got);
        end
    endtask

    task automatic test_mask_change();
        int n;
        int adv_idx[$];
        int adv_fd[$];
        logic [2:0] prev;
        do_reset();
        dwell = 16'd3; mask = 8'hFF; en = 1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(sel_valid && {a, b, c} == 3'd1) && n < 100);
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL mask_wait got=timeout exp=idx1_active");
        end
        mask = 8'h81;
        prev = {a, b, c};
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++;
            if (got !== expv()) begin
                errors++;
                $display("FAIL mask_chg cyc=%0d got=%b exp=%b", i, got, expv());
            end
            if ({a, b, c} != prev) begin
                adv_idx.push_back(int'({a, b, c}));
                adv_fd.push_back(int'(frame_done));
            end
            prev = {a, b, c};
        end
        checks++;
        if (adv_idx.size() < 2 || adv_idx[0] != 7 || adv_fd[0] != 0 ||
            adv_idx[1] != 0 || adv_fd[1] != 1) begin
            errors++;
            $display("FAIL mask_seq got=%p/%p exp='{7,0}/'{0,1}",
                     adv_idx, adv_fd);
        end
    endtask

    task automatic test_random();
        do_reset();
        mask = 8'($urandom); en = 1; dwell = 16'($urandom_range(0, 4));
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mask = 8'($urandom);
            en    = ($urandom_range(0, 29) != 0);
            dwell = 16'($urandom_range(0, 4));
            rst   = ($urandom_range(0, 99) == 0);
            cycle();
            checks++;
            if (got !== expv()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, got, expv());
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; en = 0; mask = 8'h00; dwell = 16'd0;
        m_run = 0; m_fd = 0; m_ch = 0; m_t = 0; m_d = 1;
        test_reset();
        test_full_sweep();
        test_sparse();
        test_single();
        test_abort();
        test_mask_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 3-to-8 decoder.
- Steps a 3-bit channel index {a,b,c} through the enabled channels of an 8-bit mask, round-robin, holding each channel for a programmable dwell time.
- Inserts a blanking gap between channels (sel_valid low) so downstream one-hot loads never overlap.
- Pulses frame_done once per full sweep. Typical use: display-digit or keypad-row multiplexing.

Parameters:
- DWELL_W, 16, width of dwell input (cycles per channel).
- BLANK_CYCLES, 2, blanking cycles before each channel's active window; legal range 1 to 255 (values below 1 are a synthesis-time error).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  run enable
- mask  input  8  channel enable; bit i enables index i
- dwell  input  DWELL_W  active cycles per channel; 0 treated as 1
- a  output  1  index bit 2 (MSB), feeds decoder a
- b  output  1  index bit 1, feeds decoder b
- c  output  1  index bit 0 (LSB), feeds decoder c
- sel_valid  output  1  high only in ACTIVE; gates decoder outputs
- frame_done  output  1  one-cycle pulse on wrap to a new frame
- busy  output  1  high whenever state is not IDLE

Behaviour:
- All outputs registered. On rst: {a,b,c}=0, sel_valid=0, frame_done=0, busy=0, state=IDLE, counter=0. rst has priority over every other input.
- States: IDLE, BLANK, ACTIVE. cnt is an internal down-counter, width max(DWELL_W, 8).
- IDLE, en=1 and mask!=0: next cycle BLANK; idx = lowest set bit of mask; cnt=BLANK_CYCLES-1.
- IDLE otherwise: stay; idx holds last value; sel_valid=0.
- BLANK: sel_valid=0; idx already at the new channel.
  - cnt!=0: decrement.
  - cnt==0: go ACTIVE; cnt = max(dwell,1)-1. dwell is sampled at this transition only.
- ACTIVE: sel_valid=1.
  - cnt!=0: decrement.
  - cnt==0: go BLANK; idx = next set bit of current mask strictly after idx, wrapping 7->0; cnt=BLANK_CYCLES-1.
- frame_done=1 for exactly the cycle in which the new idx is registered, when new idx <= old idx (wrap). With a single enabled channel, it pulses on every advance.
- frame_done never pulses on the IDLE->BLANK start.
- Per-channel period = BLANK_CYCLES + max(dwell,1). Frame length = period x popcount(mask).
- mask is sampled at each advance. Clearing bits affects only later selections; the current channel finishes its dwell.
- mask==0 while in BLANK or ACTIVE: next cycle IDLE, sel_valid=0, idx held.
- en=0 while in BLANK or ACTIVE: next cycle IDLE, sel_valid=0, idx held, no frame_done.
- Re-enable from IDLE always restarts at the lowest set bit.
- rst asserted mid-operation: next cycle equals the reset state, regardless of en.
- {a,b,c} changes only on the IDLE->BLANK or ACTIVE->BLANK edge, never while sel_valid=1.

Test Plan:
- Reset check: rst=1 for 3 cycles with en=1, mask=8'hFF -> a,b,c,sel_valid,frame_done,busy all 0. First BLANK occurs 1 cycle after rst falls.
- Full sweep: BLANK_CYCLES=2, dwell=3, mask=8'hFF, en held high -> idx 0..7 in order; sel_valid 3 cycles high / 2 low per channel; 40-cycle frame; frame_done single pulse on the 7->0 transition, none at start.
- Sparse mask: mask=8'b1010_0100, dwell=1 -> sequence 2,5,7,2,...; period 3 cycles; frame_done on the 7->2 transition.
- Single channel and dwell=0: mask=8'h10, dwell=0 -> idx stays 4; sel_valid 1 cycle high every 3 cycles; frame_done pulses at every advance.
- Abort paths:
  - Drop en during ACTIVE on idx 3 -> next cycle busy=0, sel_valid=0, idx=3.
  - Re-assert en with mask=8'h0C -> restart at idx 2.
  - Set mask=0 during BLANK -> IDLE next cycle.
- Mid-run mask change: mask=8'hFF; during idx 1's ACTIVE window switch to 8'h81 -> idx 1 completes its dwell, then 7, then 0 with frame_done.
